// File: rtl/debug_strgen.sv
// Debug string generator: snapshots PC / instruction / one register, renders them as hex
// ASCII one nibble per cycle into a shadow buffer, then commits the 32-char frame atomically.
module debug_strgen #(
  parameter int REFRESH_CYCLES = 5_000_000
) (
  input  logic         CCLK,
  input  logic         reset,
  input  logic [31:0]  pc,
  input  logic [31:0]  inst,
  input  logic [4:0]   regsel,
  input  logic [31:0]  regdata,
  input  logic         step,
  output logic [4:0]   regaddr,
  output logic [255:0] strdata,
  output logic         busy,
  output logic         strvalid
);

  localparam int CW = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, CAPTURE, CONVERT, COMMIT} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  regsel;
    logic [31:0] rdat;
  } snap_t;

  state_t         state_q, state_d;
  snap_t          snap;
  logic [CW-1:0]  cnt;
  logic           tick, pending, start;
  logic [4:0]     idx_q;
  logic [255:0]   shadow;
  logic [103:0]   seq;
  logic [3:0]     nib;
  logic [4:0]     pos;
  logic [7:0]     asc;

  assign tick    = (cnt == CW'(REFRESH_CYCLES - 1));
  assign start   = tick | step | pending;
  assign busy    = (state_q != IDLE);
  assign regaddr = snap.regsel;

  always_ff @(posedge CCLK or negedge reset) begin
    if (!reset) cnt <= '0;
    else        cnt <= tick ? '0 : cnt + 1'b1;
  end

  always_ff @(posedge CCLK or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CAPTURE;
      CAPTURE: state_d = CONVERT;
      CONVERT: if (idx_q == 5'd25) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // All 26 variable nibbles in display order; idx 0 is the MS nibble of pc.
  assign seq = {snap.pc, 3'b000, snap.regsel, snap.inst, snap.rdat};

  always_comb begin
    nib = seq[7'd103 - {idx_q, 2'b00} -: 4];
    if (idx_q < 5'd8)       pos = idx_q + 5'd3;
    else if (idx_q < 5'd10) pos = idx_q + 5'd5;
    else                    pos = idx_q + 5'd6;
    asc = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  end

  always_ff @(posedge CCLK or negedge reset) begin
    if (!reset) begin
      snap     <= '0;
      pending  <= 1'b0;
      idx_q    <= '0;
      shadow   <= {32{8'h20}};
      strdata  <= {32{8'h20}};
      strvalid <= 1'b0;
    end else begin
      strvalid <= 1'b0;
      // Requests arriving while busy collapse into a single deferred frame.
      if (state_q == IDLE) begin
        if (start) pending <= 1'b0;
      end else if (tick | step) begin
        pending <= 1'b1;
      end
      case (state_q)
        IDLE: if (start) begin
          snap.pc     <= pc;
          snap.inst   <= inst;
          snap.regsel <= regsel;
        end
        CAPTURE: begin
          snap.rdat      <= regdata;
          idx_q          <= '0;
          shadow[255 -: 24] <= "PC=";
          shadow[167 -: 16] <= " R";
          shadow[135 -: 8]  <= 8'h20;
        end
        CONVERT: begin
          shadow[8'd255 - {pos, 3'b000} -: 8] <= asc;
          idx_q <= idx_q + 1'b1;
        end
        COMMIT: begin
          strdata  <= shadow;
          strvalid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_strgen.sv
// Directed bench for debug_strgen: frame content, latency, request merging, periodic refresh, abort.
module tb_debug_strgen;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  pc, inst, regdata;
  logic [4:0]   regsel;
  logic         step, step_b;
  logic [4:0]   regaddr, regaddr_b;
  logic [255:0] strdata, strdata_b;
  logic         busy, busy_b, strvalid, strvalid_b;

  int n_chk = 0;
  int n_fail = 0;

  localparam logic [255:0] SPACES = {32{8'h20}};

  always #5 clk = ~clk;

  // Main instance: refresh period far beyond the run, so only step starts frames.
  debug_strgen #(.REFRESH_CYCLES(100000)) dut (
    .CCLK(clk), .reset(reset), .pc(pc), .inst(inst), .regsel(regsel),
    .regdata(regdata), .step(step), .regaddr(regaddr), .strdata(strdata),
    .busy(busy), .strvalid(strvalid)
  );

  // Short-period instance for periodic refresh behaviour.
  debug_strgen #(.REFRESH_CYCLES(40)) dut_b (
    .CCLK(clk), .reset(reset), .pc(pc), .inst(inst), .regsel(regsel),
    .regdata(regdata), .step(step_b), .regaddr(regaddr_b), .strdata(strdata_b),
    .busy(busy_b), .strvalid(strvalid_b)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic [255:0] f2, f3, f4a, f4b;
    int npulse;
    int pulses[$];
    f2  = "PC=0040001C R08 8C080004DEADBEEF";
    f3  = "PC=1234ABCD R1F FFFF00000F1E2D3C";
    f4a = "PC=CAFEF00D R01 0000000000000009";
    f4b = "PC=00000001 R01 0000000000000009";
    pc = '0; inst = '0; regsel = '0; regdata = '0; step = 1'b0; step_b = 1'b0;
    reset = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_str", strdata, SPACES);
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_sv", 256'(strvalid), 256'(0));
    chk("rst_raddr", 256'(regaddr), 256'(0));
    reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_str", strdata, SPACES);
    chk("idle_busy", 256'(busy), 256'(0));

    // Basic frame and 28-edge latency
    pc = 32'h0040_001C; inst = 32'h8C08_0004; regsel = 5'd8; regdata = 32'hDEAD_BEEF;
    step = 1'b1;
    for (int k = 0; k <= 30; k++) begin
      @(negedge clk);
      step = 1'b0;
      if (k == 0)  chk("t2_busy", 256'(busy), 256'(1));
      if (k == 0)  chk("t2_raddr", 256'(regaddr), 256'(8));
      if (k == 27) chk("t2_hold", strdata, SPACES);
      if (k == 27) chk("t2_sv27", 256'(strvalid), 256'(0));
      if (k == 28) chk("t2_frame", strdata, f2);
      if (k == 28) chk("t2_sv28", 256'(strvalid), 256'(1));
      if (k == 28) chk("t2_idle", 256'(busy), 256'(0));
      if (k == 29) chk("t2_sv29", 256'(strvalid), 256'(0));
    end

    // Inputs churning mid-conversion must not disturb the snapshot
    pc = 32'h1234_ABCD; inst = 32'hFFFF_0000; regsel = 5'd31; regdata = 32'h0F1E_2D3C;
    step = 1'b1;
    for (int k = 0; k <= 29; k++) begin
      @(negedge clk);
      step = 1'b0;
      if (k == 0) chk("t3_raddr", 256'(regaddr), 256'(31));
      pc = $urandom; inst = $urandom; regsel = 5'($urandom);
      if (k >= 1) regdata = $urandom;
      if (k == 27) chk("t3_hold", strdata, f2);
      if (k == 28) chk("t3_frame", strdata, f3);
    end

    // Two requests while busy merge into exactly one follow-on frame
    pc = 32'hCAFE_F00D; inst = 32'h0; regsel = 5'd1; regdata = 32'h9;
    step = 1'b1;
    npulse = 0;
    for (int k = 0; k <= 80; k++) begin
      @(negedge clk);
      step = (k == 5 || k == 10);
      if (k == 20) pc = 32'h0000_0001;
      if (strvalid) npulse++;
      if (k == 28) chk("t4_frame1", strdata, f4a);
      if (k == 28) chk("t4_sv1", 256'(strvalid), 256'(1));
      if (k == 29) chk("t4_restart", 256'(busy), 256'(1));
      if (k == 57) chk("t4_frame2", strdata, f4b);
      if (k == 57) chk("t4_sv2", 256'(strvalid), 256'(1));
    end
    chk("t4_npulse", 256'(npulse), 256'(2));

    // Reset in the middle of a conversion aborts cleanly
    pc = 32'h0040_001C; inst = 32'h8C08_0004; regsel = 5'd8; regdata = 32'hDEAD_BEEF;
    step = 1'b1;
    for (int k = 0; k <= 15; k++) begin
      @(negedge clk);
      step = 1'b0;
    end
    reset = 1'b0;
    #1;
    chk("t6_str", strdata, SPACES);
    chk("t6_busy", 256'(busy), 256'(0));
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("t6_still", strdata, SPACES);
    step = 1'b1;
    for (int k = 0; k <= 28; k++) begin
      @(negedge clk);
      step = 1'b0;
      if (k == 27) chk("t6_hold", strdata, SPACES);
      if (k == 28) chk("t6_frame", strdata, f2);
    end

    // Periodic refresh (period 40); a step at edge 12 makes the edge-40 tick land on COMMIT
    do_reset();
    for (int c = 1; c <= 160; c++) begin
      @(negedge clk);
      step_b = (c == 11);
      if (strvalid_b) pulses.push_back(c);
    end
    chk("t5_npulse", 256'(pulses.size()), 256'(4));
    if (pulses.size() == 4) begin
      chk("t5_p0", 256'(pulses[0]), 256'(40));
      chk("t5_p1", 256'(pulses[1]), 256'(69));
      chk("t5_p2", 256'(pulses[2]), 256'(108));
      chk("t5_p3", 256'(pulses[3]), 256'(148));
    end
    chk("t5_frame", strdata_b, f2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
